// File: rtl/card_pkg.sv
// Shared types and constants for the card board writer/readers.
// Board geometry, card ID encoding and dealer FSM states.
package card_pkg;

  localparam int N_CELLS = 36;
  localparam int CARD_W  = 5;
  localparam int ADDR_W  = $clog2(N_CELLS);
  localparam int LFSR_W  = 16;

  localparam logic [LFSR_W-1:0] LFSR_MASK  = 16'hB400;
  localparam logic [CARD_W-1:0] CARD_EMPTY = 5'h1F;

  typedef logic [CARD_W-1:0] card_t;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {
    IDLE,
    INIT,
    SHUFFLE,
    DONE
  } dealer_state_t;

  function automatic logic [4:0] pairs_for_level(
    input logic [1:0] lv
  );
    logic [4:0] p;
    unique case (1'b1)
      (lv == 2'd0): p = 5'd8;
      (lv == 2'd1): p = 5'd12;
      default:      p = 5'd18;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/card_dealer_lfsr16.sv
// 16-bit right-shifting Galois LFSR with synchronous load.
// Shared by the dealer shuffle and the game timer.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1,
  parameter logic [15:0] MASK = 16'hB400
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [15:0] q
);

  logic [15:0] r_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_q <= SEED;
    end else if (load) begin
      r_q <= load_val;
    end else begin
      r_q <= (r_q >> 1) ^ (r_q[0] ? MASK : 16'h0000);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/card_dealer.sv
// Card dealer: fills and Fisher-Yates shuffles the 6x6 board.
// DEALER_SEED_PORT_EN adds seed_in, loaded into the LFSR on deal start.
module card_dealer
  import card_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  level,
`ifdef DEALER_SEED_PORT_EN
  input  logic [15:0] seed_in,
`endif
  output logic        busy,
  output logic        done,
  output logic        ready,
  output logic [4:0]  pairs,
  input  logic [5:0]  rd_addr1,
  input  logic [5:0]  rd_addr2,
  output card_t       rd_data1,
  output card_t       rd_data2
);

  localparam addr_t LAST = addr_t'(N_CELLS - 1);
  localparam addr_t NC   = addr_t'(N_CELLS);

  dealer_state_t r_state;
  dealer_state_t w_next;

  card_t       r_board [N_CELLS];
  addr_t       r_n;
  addr_t       r_k;
  addr_t       r_i;
  logic [4:0]  r_pairs;
  logic        r_ready;

  logic [15:0] w_lfsr;
  logic        w_accept;
  logic        w_load;
  logic [15:0] w_load_val;
  addr_t       w_m;
  addr_t       w_r;
  logic        w_hit;
  logic        w_unused_lfsr;

  assign w_accept = (r_state == IDLE) && start;

`ifdef DEALER_SEED_PORT_EN
  assign w_load     = w_accept;
  assign w_load_val = (seed_in == 16'h0000) ? SEED : seed_in;
`else
  assign w_load     = 1'b0;
  assign w_load_val = SEED;
`endif

  lfsr16 #(
    .SEED (SEED),
    .MASK (LFSR_MASK)
  ) u_lfsr (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (w_load),
    .load_val (w_load_val),
    .q        (w_lfsr)
  );

  assign w_unused_lfsr = ^w_lfsr[15:6];

  // smear i down to the enclosing all-ones mask
  assign w_m = r_i | (r_i >> 1) | (r_i >> 2)
             | (r_i >> 3) | (r_i >> 4) | (r_i >> 5);
  assign w_r   = w_lfsr[5:0] & w_m;
  assign w_hit = (r_state == SHUFFLE) && (w_r <= r_i);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next = INIT;
      INIT:    if (r_k == LAST) w_next = SHUFFLE;
      SHUFFLE: if (w_hit && (r_i == 6'd1)) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_n     <= '0;
      r_k     <= '0;
      r_i     <= '0;
      r_pairs <= '0;
      r_ready <= 1'b0;
      for (int c = 0; c < N_CELLS; c++) begin
        r_board[c] <= CARD_EMPTY;
      end
    end else begin
      if (w_accept) begin
        r_pairs <= pairs_for_level(level);
        r_n     <= {pairs_for_level(level), 1'b0};
        r_k     <= '0;
        r_ready <= 1'b0;
      end
      if (r_state == INIT) begin
        r_board[r_k] <= (r_k < r_n) ? card_t'(r_k >> 1)
                                    : CARD_EMPTY;
        r_k <= r_k + 6'd1;
        if (r_k == LAST) begin
          r_i <= r_n - 6'd1;
        end
      end
      if (w_hit) begin
        r_board[r_i] <= r_board[w_r];
        r_board[w_r] <= r_board[r_i];
        r_i          <= r_i - 6'd1;
        if (r_i == 6'd1) begin
          r_ready <= 1'b1;
        end
      end
    end
  end

  assign busy  = (r_state == INIT) || (r_state == SHUFFLE);
  assign done  = (r_state == DONE);
  assign ready = r_ready;
  assign pairs = r_pairs;

  assign rd_data1 = (rd_addr1 < NC) ? r_board[rd_addr1] : CARD_EMPTY;
  assign rd_data2 = (rd_addr2 < NC) ? r_board[rd_addr2] : CARD_EMPTY;

endmodule

// File: tb/tb_card_dealer.sv
// Self-checking bench for card_dealer.
// Reference deal is recomputed from the LFSR and Fisher-Yates rules.
module tb_card_dealer;
  import card_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  level = 2'd0;
  logic        busy, done, ready;
  logic [4:0]  pairs;
  logic [5:0]  rd_addr1 = 6'd0;
  logic [5:0]  rd_addr2 = 6'd0;
  card_t       rd_data1, rd_data2;
`ifdef DEALER_SEED_PORT_EN
  logic [15:0] seed_in = 16'h0000;
`endif

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  card_dealer dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .level    (level),
`ifdef DEALER_SEED_PORT_EN
    .seed_in  (seed_in),
`endif
    .busy     (busy),
    .done     (done),
    .ready    (ready),
    .pairs    (pairs),
    .rd_addr1 (rd_addr1),
    .rd_addr2 (rd_addr2),
    .rd_data1 (rd_data1),
    .rd_data2 (rd_data2)
  );

  function automatic logic [15:0] adv(input logic [15:0] x);
    return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
  endfunction

  // free-running reference LFSR, reloaded on accepted seeded starts
  logic [15:0] m_lfsr;
  logic        m_load = 1'b0;
  logic [15:0] m_seed = 16'h0000;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) m_lfsr <= 16'hACE1;
    else if (m_load) m_lfsr <= m_seed;
    else m_lfsr <= adv(m_lfsr);
  end

  card_t exp_b [36];
  card_t got_b [36];
  card_t sav_b [36];
  int    exp_a;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [15:0] l0, input bit ld,
                       input logic [15:0] sd, input int np);
    logic [15:0] l;
    int n, i, m, r;
    card_t t;
    n = 2 * np;
    for (int k = 0; k < 36; k++)
      exp_b[k] = (k < n) ? card_t'(k / 2) : 5'h1F;
    l = ld ? ((sd == 16'h0) ? 16'hACE1 : sd) : adv(l0);
    repeat (36) l = adv(l);
    i = n - 1;
    exp_a = 0;
    while (exp_a < 5000) begin
      m = 1;
      while (m < i) m = 2 * m + 1;
      r = int'(l[5:0]) & m;
      exp_a++;
      if (r <= i) begin
        t = exp_b[i];
        exp_b[i] = exp_b[r];
        exp_b[r] = t;
        if (i == 1) break;
        i--;
      end
      l = adv(l);
    end
  endtask

  // mode 1: extra start 10 cycles in; mode 2: start during DONE
  task automatic deal(input logic [1:0] lv, input int gap,
                      input int mode, input string tag);
    logic [15:0] l0;
    int np, n, cnt;
    int cnt_id [32];
    bit ld;
    repeat (gap) @(negedge clock);
    np = (lv == 2'd0) ? 8 : (lv == 2'd1) ? 12 : 18;
    n = 2 * np;
    l0 = m_lfsr;
    ld = 1'b0;
    level = lv;
    start = 1'b1;
`ifdef DEALER_SEED_PORT_EN
    ld = 1'b1;
    m_seed = (seed_in == 16'h0) ? 16'hACE1 : seed_in;
    m_load = 1'b1;
    model(l0, ld, seed_in, np);
`else
    model(l0, ld, 16'h0, np);
`endif
    @(negedge clock);
    start = 1'b0;
    m_load = 1'b0;
    chk({tag, ".busy_on"}, busy, 1);
    chk({tag, ".ready_clr"}, ready, 0);
    cnt = 0;
    while (!done && cnt < 3000) begin
      if (busy) cnt++;
      if (mode == 1 && cnt == 10) begin
        start = 1'b1;
        level = 2'd2;
      end else begin
        start = 1'b0;
      end
      @(negedge clock);
    end
    chk({tag, ".done"}, done, 1);
    chk({tag, ".busy_len"}, cnt, 36 + exp_a);
    chk({tag, ".ready_done"}, ready, 1);
    chk({tag, ".pairs"}, pairs, np);
    start = (mode == 2);
    @(negedge clock);
    start = 1'b0;
    chk({tag, ".done_1cyc"}, done, 0);
    chk({tag, ".busy_off"}, busy, 0);
    chk({tag, ".ready_held"}, ready, 1);
    for (int k = 0; k < 32; k++) cnt_id[k] = 0;
    for (int k = 0; k < 36; k++) begin
      rd_addr1 = 6'(k);
      rd_addr2 = 6'(35 - k);
      #1;
      got_b[k] = rd_data1;
      chk($sformatf("%s.cell%0d", tag, k), rd_data1, exp_b[k]);
      chk($sformatf("%s.cellb%0d", tag, 35 - k), rd_data2,
          exp_b[35 - k]);
      if (k >= n) chk($sformatf("%s.empty%0d", tag, k), rd_data1, 5'h1F);
      else cnt_id[rd_data1]++;
    end
    for (int d = 0; d < np; d++)
      chk($sformatf("%s.twice%0d", tag, d), cnt_id[d], 2);
    rd_addr1 = 6'd40;
    rd_addr2 = 6'd63;
    #1;
    chk({tag, ".oob1"}, rd_data1, 5'h1F);
    chk({tag, ".oob2"}, rd_data2, 5'h1F);
    @(negedge clock);
  endtask

  initial begin
    int dn;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.ready", ready, 0);
    chk("rst.pairs", pairs, 0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("rel.busy", busy, 0);
    chk("rel.ready", ready, 0);
    rd_addr1 = 6'd0;
    #1 chk("rel.cell0", rd_data1, 5'h1F);
    rd_addr1 = 6'd35;
    #1 chk("rel.cell35", rd_data1, 5'h1F);
    @(negedge clock);

`ifdef DEALER_SEED_PORT_EN
    seed_in = 16'h1234;
    deal(2'd2, 3, 0, "seedA");
    for (int k = 0; k < 36; k++) sav_b[k] = got_b[k];
    deal(2'd2, 17, 0, "seedB");
    dn = 0;
    for (int k = 0; k < 36; k++) if (got_b[k] !== sav_b[k]) dn++;
    chk("seed.repeat", dn, 0);
    seed_in = 16'hACE1;
    deal(2'd1, 5, 0, "seedC");
    for (int k = 0; k < 36; k++) sav_b[k] = got_b[k];
    seed_in = 16'h0000;
    deal(2'd1, 9, 0, "seedZ");
    dn = 0;
    for (int k = 0; k < 36; k++) if (got_b[k] !== sav_b[k]) dn++;
    chk("seed.zero", dn, 0);
`endif

    deal(2'd2, $urandom_range(0, 40), 0, "full");
    deal(2'd0, $urandom_range(0, 40), 0, "lvl0");
    deal(2'd1, $urandom_range(0, 40), 1, "restart");
    deal(2'd2, $urandom_range(0, 40), 2, "donestart");

    level = 2'd2;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (50) @(negedge clock);
    chk("mid.busy", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("mid.busy0", busy, 0);
    chk("mid.ready0", ready, 0);
    chk("mid.pairs0", pairs, 0);
    dn = 0;
    for (int k = 0; k < 36; k++) begin
      rd_addr1 = 6'(k);
      #1;
      if (rd_data1 !== 5'h1F) dn++;
    end
    chk("mid.cleared", dn, 0);
    @(negedge clock);
    reset_n = 1'b1;
    dn = 0;
    repeat (80) begin
      @(negedge clock);
      if (done) dn++;
    end
    chk("mid.nodone", dn, 0);

    for (int t = 0; t < 3; t++)
      deal(2'($urandom_range(0, 3)), $urandom_range(0, 60), 0,
           $sformatf("rnd%0d", t));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
